// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC generator, single-outstanding SRAM request port
// and a DEPTH-entry prefetch queue with valid/ready toward decode.
module fetch_prefetch_unit #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     enable,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_ren,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [DATA_W-1:0]        id_instr,
    output logic [ADDR_W-1:0]        id_pc_next,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_next;
    } entry_t;

    entry_t            q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_pc, req_pc_next;
    logic              inflight, req_epoch, epoch;
    logic              issue, push, pop;

    // Credit includes the outstanding request so a response always has a slot.
    assign issue = enable & ~arst & ~redirect &
                   ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
    assign push  = inflight & (req_epoch == epoch);
    assign pop   = id_valid & id_ready;

    assign imem_ren   = issue;
    assign imem_addr  = fetch_pc;
    assign id_valid   = (count != '0);
    assign id_instr   = q[rd_ptr].instr;
    assign id_pc_next = q[rd_ptr].pc_next;
    assign fill_level = count;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_pc    <= RESET_PC;
            req_pc_next <= '0;
            inflight    <= 1'b0;
            req_epoch   <= 1'b0;
            epoch       <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (redirect) begin
            // Flush everything; the epoch flip kills any response still on its way.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            epoch    <= ~epoch;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
                req_pc_next <= fetch_pc + ADDR_W'(PC_STEP);
                req_epoch   <= epoch;
            end
            if (push) begin
                q[wr_ptr] <= '{instr: imem_rdata, pc_next: req_pc_next};
                wr_ptr    <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) assert (count <= CNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a 1-cycle SRAM model where
// the word at byte address a is 0x1000_0000 + a/4.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc_next;
    logic [2:0]  fill_level;

    int passed = 0;
    int total  = 0;
    int issued = 0;

    fetch_prefetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .RESET_PC('0), .PC_STEP(4)) dut (
        .clk(clk), .arst(arst), .enable(enable),
        .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc_next(id_pc_next), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) if (imem_ren) imem_rdata <= word(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        arst = 1'b1; enable = 1'b0; id_ready = 1'b0; redirect = 1'b0;
        cyc(); cyc();
        arst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        cyc(); cyc();
        check("rst_valid", id_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ren", imem_ren, 0);
        check("rst_instr", id_instr, 0);
        check("rst_pcnext", id_pc_next, 0);
        check("rst_addr", imem_addr, 0);

        // streaming: addresses 0,4,8..; first delivery at cycle 2
        apply_reset();
        enable = 1'b1; id_ready = 1'b1; #1;
        check("s_ren0", imem_ren, 1);
        check("s_addr0", imem_addr, 0);
        check("s_valid0", id_valid, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("s_addr", imem_addr, 32'(4 * i));
            if (i == 1) check("s_valid1", id_valid, 0);
            else begin
                check("s_valid", id_valid, 1);
                check("s_instr", id_instr, 32'h1000_0000 + 32'(i - 2));
                check("s_pcnext", id_pc_next, 32'(4 * (i - 1)));
            end
        end

        // back-pressure: exactly 4 fetches, then in-order drain
        apply_reset();
        enable = 1'b1; id_ready = 1'b0; #1;
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            issued += int'(imem_ren);
        end
        check("bp_issued", 64'(issued), 4);
        check("bp_fill", fill_level, 4);
        check("bp_ren", imem_ren, 0);
        cyc();
        id_ready = 1'b1; #1;
        check("bp_fill10", fill_level, 4);
        check("bp_head0", id_instr, 32'h1000_0000);
        cyc();
        check("bp_head1", id_instr, 32'h1000_0001);
        check("bp_ren11", imem_ren, 1);
        check("bp_addr11", imem_addr, 16);
        cyc();
        check("bp_head2", id_instr, 32'h1000_0002);
        cyc();
        check("bp_head3", id_instr, 32'h1000_0003);

        // redirect with 3 queued and 1 in flight
        apply_reset();
        enable = 1'b1; id_ready = 1'b0; #1;
        repeat (4) cyc();
        check("rd_fill_pre", fill_level, 3);
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        check("rd_ren_during", imem_ren, 0);
        cyc();
        redirect = 1'b0; id_ready = 1'b1; #1;
        check("rd_fill", fill_level, 0);
        check("rd_valid", id_valid, 0);
        check("rd_addr", imem_addr, 32'h200);
        check("rd_ren", imem_ren, 1);
        cyc();
        check("rd_valid6", id_valid, 0);
        check("rd_fill6", fill_level, 0);
        cyc();
        check("rd_valid7", id_valid, 1);
        check("rd_instr", id_instr, 32'h1000_0080);
        check("rd_pcnext", id_pc_next, 32'h204);

        // back-to-back redirects: last wins
        cyc();
        redirect = 1'b1; redirect_pc = 32'h100; #1;
        cyc();
        redirect_pc = 32'h300; #1;
        cyc();
        redirect = 1'b0; #1;
        check("rr_fill", fill_level, 0);
        check("rr_valid", id_valid, 0);
        check("rr_addr", imem_addr, 32'h300);
        cyc();
        check("rr_valid11", id_valid, 0);
        cyc();
        check("rr_valid12", id_valid, 1);
        check("rr_instr", id_instr, 32'h1000_00C0);
        check("rr_pcnext", id_pc_next, 32'h304);
        cyc();
        check("rr_instr2", id_instr, 32'h1000_00C1);

        // enable drop with 2 queued and 1 in flight
        apply_reset();
        enable = 1'b1; id_ready = 1'b0; #1;
        repeat (3) cyc();
        check("en_fill_pre", fill_level, 2);
        enable = 1'b0; id_ready = 1'b1; #1;
        check("en_ren3", imem_ren, 0);
        check("en_instr0", id_instr, 32'h1000_0000);
        cyc();
        check("en_instr1", id_instr, 32'h1000_0001);
        check("en_ren4", imem_ren, 0);
        cyc();
        check("en_valid5", id_valid, 1);
        check("en_instr2", id_instr, 32'h1000_0002);
        cyc();
        check("en_valid6", id_valid, 0);
        check("en_ren6", imem_ren, 0);
        enable = 1'b1; #1;
        check("en_resume_ren", imem_ren, 1);
        check("en_resume_addr", imem_addr, 12);
        cyc();
        check("en_valid7", id_valid, 0);
        cyc();
        check("en_instr3", id_instr, 32'h1000_0003);
        check("en_pcnext3", id_pc_next, 16);

        // asynchronous reset pulse mid-stream
        cyc(); cyc();
        check("ar_valid_pre", id_valid, 1);
        check("ar_instr_pre", id_instr, 32'h1000_0005);
        #1 arst = 1'b1;
        #1;
        check("ar_valid", id_valid, 0);
        check("ar_fill", fill_level, 0);
        check("ar_ren", imem_ren, 0);
        check("ar_instr", id_instr, 0);
        check("ar_pcnext", id_pc_next, 0);
        arst = 1'b0; #1;
        check("ar_ren_rel", imem_ren, 1);
        check("ar_addr_rel", imem_addr, 0);
        cyc();
        check("ar_valid1", id_valid, 0);
        check("ar_fill1", fill_level, 0);
        cyc();
        check("ar_valid2", id_valid, 1);
        check("ar_instr2", id_instr, 32'h1000_0000);
        check("ar_pcnext2", id_pc_next, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
